// File: rtl/flags_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flags_pkg
// Description : Shared definitions for the NZCV flag register and B.cond
//               condition evaluation (condition code enum, flag bit indices).
// Revision    : 1.0 - initial release
// ============================================================================
package flags_pkg;

    // B.cond condition field encoding (instr[3:0])
    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        HS = 4'h2,
        LO = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    // Bit positions inside the packed {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : flags_pkg
`default_nettype wire

// File: rtl/flags_cond_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational B.cond condition evaluator. Takes a
//               4-bit condition code and the {N,Z,C,V} flags and reports
//               whether the condition holds. Shared with the fetch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import flags_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    // Decode each condition code against the current flags; NV behaves as AL.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            EQ:      cond_true = w_z;
            NE:      cond_true = ~w_z;
            HS:      cond_true = w_c;
            LO:      cond_true = ~w_c;
            MI:      cond_true = w_n;
            PL:      cond_true = ~w_n;
            VS:      cond_true = w_v;
            VC:      cond_true = ~w_v;
            HI:      cond_true = w_c & ~w_z;
            LS:      cond_true = ~(w_c & ~w_z);
            GE:      cond_true = (w_n == w_v);
            LT:      cond_true = (w_n != w_v);
            GT:      cond_true = ~w_z & (w_n == w_v);
            LE:      cond_true = ~(~w_z & (w_n == w_v));
            AL:      cond_true = 1'b1;
            NV:      cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/flags_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : flags_cond_unit
// Description : Captures ALU flags into the architectural NZCV register,
//               evaluates B.cond in EX against the current (pre-write) flags,
//               registers the taken decision into MEM and keeps saturating
//               taken / not-taken statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module flags_cond_unit
    import flags_pkg::*;
#(
    parameter int         CNT_WIDTH = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic                 ex_write_flags,
    input  logic                 ex_N,
    input  logic                 ex_Z,
    input  logic                 ex_C,
    input  logic                 ex_V,
    input  logic                 ex_is_bcond,
    input  logic [3:0]           ex_cond,
    input  logic                 stall,
    input  logic                 flush,
    output logic [3:0]           flags,
    output logic                 mem_bcond_valid,
    output logic                 mem_taken,
    output logic [CNT_WIDTH-1:0] cnt_taken,
    output logic [CNT_WIDTH-1:0] cnt_not_taken
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [3:0]           flags_q,           flags_d;
    logic                 mem_bcond_valid_q, mem_bcond_valid_d;
    logic                 mem_taken_q,       mem_taken_d;
    logic [CNT_WIDTH-1:0] cnt_taken_q,       cnt_taken_d;
    logic [CNT_WIDTH-1:0] cnt_not_taken_q,   cnt_not_taken_d;

    logic w_fire;
    logic w_cond_true;
    logic w_ex_bcond;

    // Evaluation always sees the flags as they stand before this edge's write,
    // so a setter followed by a B.cond needs no forwarding path.
    cond_eval u_cond_eval (
        .cond      (ex_cond),
        .flags     (flags_q),
        .cond_true (w_cond_true)
    );

    assign w_fire     = ex_valid & ~stall & ~flush;
    assign w_ex_bcond = ex_valid & ex_is_bcond;

    // Next-state for flags, MEM slot and statistics counters.
    always_comb begin
        flags_d           = flags_q;
        mem_bcond_valid_d = mem_bcond_valid_q;
        mem_taken_d       = mem_taken_q;
        cnt_taken_d       = cnt_taken_q;
        cnt_not_taken_d   = cnt_not_taken_q;

        if (w_fire && ex_write_flags) begin
            flags_d = {ex_N, ex_Z, ex_C, ex_V};
        end

        // Flush outranks stall: a killed slot never lingers in MEM.
        if (flush) begin
            mem_bcond_valid_d = 1'b0;
            mem_taken_d       = 1'b0;
        end else if (!stall) begin
            mem_bcond_valid_d = w_ex_bcond;
            mem_taken_d       = w_ex_bcond & w_cond_true;
        end

        if (w_fire && ex_is_bcond) begin
            if (w_cond_true) begin
                if (cnt_taken_q != C_CNT_MAX) begin
                    cnt_taken_d = cnt_taken_q + C_CNT_ONE;
                end
            end else begin
                if (cnt_not_taken_q != C_CNT_MAX) begin
                    cnt_not_taken_d = cnt_not_taken_q + C_CNT_ONE;
                end
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q           <= FLAGS_RST;
            mem_bcond_valid_q <= 1'b0;
            mem_taken_q       <= 1'b0;
            cnt_taken_q       <= '0;
            cnt_not_taken_q   <= '0;
        end else begin
            flags_q           <= flags_d;
            mem_bcond_valid_q <= mem_bcond_valid_d;
            mem_taken_q       <= mem_taken_d;
            cnt_taken_q       <= cnt_taken_d;
            cnt_not_taken_q   <= cnt_not_taken_d;
        end
    end

    assign flags           = flags_q;
    assign mem_bcond_valid = mem_bcond_valid_q;
    assign mem_taken       = mem_taken_q;
    assign cnt_taken       = cnt_taken_q;
    assign cnt_not_taken   = cnt_not_taken_q;

endmodule : flags_cond_unit
`default_nettype wire

// File: tb/tb_flags_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flags_cond_unit
// Description : Self-checking bench for flags_cond_unit. A behavioural model
//               tracks the expected architectural state each cycle; directed
//               sequences add literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flags_cond_unit;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid;
    logic          ex_write_flags;
    logic          ex_N, ex_Z, ex_C, ex_V;
    logic          ex_is_bcond;
    logic [3:0]    ex_cond;
    logic          stall;
    logic          flush;
    logic [3:0]    flags;
    logic          mem_bcond_valid;
    logic          mem_taken;
    logic [CW-1:0] cnt_taken;
    logic [CW-1:0] cnt_not_taken;

    flags_cond_unit #(
        .CNT_WIDTH (CW),
        .FLAGS_RST (4'b0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .ex_write_flags  (ex_write_flags),
        .ex_N            (ex_N),
        .ex_Z            (ex_Z),
        .ex_C            (ex_C),
        .ex_V            (ex_V),
        .ex_is_bcond     (ex_is_bcond),
        .ex_cond         (ex_cond),
        .stall           (stall),
        .flush           (flush),
        .flags           (flags),
        .mem_bcond_valid (mem_bcond_valid),
        .mem_taken       (mem_taken),
        .cnt_taken       (cnt_taken),
        .cnt_not_taken   (cnt_not_taken)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Condition table in ARM form: pairs of codes share a base test, the odd
    // member inverts it, and the last pair is always true.
    function automatic bit m_cond(input bit [3:0] f, input bit [3:0] c);
        bit n, z, cy, v, r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cy;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cy && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[3:1] != 3'd7 && c[0]) r = !r;
        return r;
    endfunction

    // Behavioural model of the architectural state.
    bit [3:0] m_flags;
    bit       m_mv, m_mt;
    int       m_ct, m_cnt;

    always @(posedge clk) begin
        bit fire, ct;
        fire = ex_valid && !stall && !flush;
        ct   = m_cond(m_flags, ex_cond);
        if (reset) begin
            m_flags = 4'b0000;
            m_mv = 0; m_mt = 0; m_ct = 0; m_cnt = 0;
        end else begin
            if (fire && ex_is_bcond) begin
                if (ct) m_ct  = (m_ct  < CMAX) ? m_ct + 1  : m_ct;
                else    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
            end
            if (flush) begin
                m_mv = 0; m_mt = 0;
            end else if (!stall) begin
                m_mv = ex_valid && ex_is_bcond;
                m_mt = m_mv && ct;
            end
            if (fire && ex_write_flags) m_flags = {ex_N, ex_Z, ex_C, ex_V};
        end
    end

    // Every-cycle comparison of DUT against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("flags", int'(flags), int'(m_flags));
            chk("mem_bcond_valid", int'(mem_bcond_valid), int'(m_mv));
            chk("mem_taken", int'(mem_taken), int'(m_mt));
            chk("cnt_taken", int'(cnt_taken), m_ct);
            chk("cnt_not_taken", int'(cnt_not_taken), m_cnt);
        end
    end

    task automatic drive(input bit rs, input bit v, input bit wf, input bit [3:0] nzcv,
                         input bit isb, input bit [3:0] c, input bit st, input bit fl);
        reset          = rs;
        ex_valid       = v;
        ex_write_flags = wf;
        {ex_N, ex_Z, ex_C, ex_V} = nzcv;
        ex_is_bcond    = isb;
        ex_cond        = c;
        stall          = st;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic setf(input bit [3:0] nzcv);
        drive(0, 1, 1, nzcv, 0, 4'h0, 0, 0);
    endtask

    task automatic br(input bit [3:0] c);
        drive(0, 1, 0, 4'h0, 1, c, 0, 0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 4'h0, 0, 4'h0, 0, 0);
    endtask

    initial begin
        int sv_ct, sv_cnt;

        // Power-on reset
        drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        chk_en = 1'b1;
        chk("rst_flags", int'(flags), 0);
        chk("rst_valid", int'(mem_bcond_valid), 0);
        chk("rst_cnt_t", int'(cnt_taken), 0);
        chk("rst_cnt_nt", int'(cnt_not_taken), 0);

        // Set then branch
        setf(4'b0100);
        chk("set_flags", int'(flags), 4'b0100);
        br(4'h0);
        chk("eq_valid", int'(mem_bcond_valid), 1);
        chk("eq_taken", int'(mem_taken), 1);
        br(4'h1);
        chk("ne_valid", int'(mem_bcond_valid), 1);
        chk("ne_taken", int'(mem_taken), 0);
        idle();
        chk("idle_valid", int'(mem_bcond_valid), 0);
        chk("idle_taken", int'(mem_taken), 0);

        // Mid-stream reset, coinciding with stall and flush
        setf(4'b1111);
        br(4'hE);
        drive(1, 1, 1, 4'b1010, 1, 4'hE, 1, 1);
        drive(1, 1, 1, 4'b1010, 1, 4'hE, 1, 1);
        chk("mrst_flags", int'(flags), 0);
        chk("mrst_valid", int'(mem_bcond_valid), 0);
        chk("mrst_cnt_t", int'(cnt_taken), 0);
        chk("mrst_cnt_nt", int'(cnt_not_taken), 0);

        // Sweep all flag patterns against all condition codes
        for (int f = 0; f < 16; f++) begin
            setf(4'(f));
            for (int c = 0; c < 16; c++) begin
                br(4'(c));
                if (f == 9 && c == 10) chk("spot_1001_GE", int'(mem_taken), 1);
                if (f == 9 && c == 11) chk("spot_1001_LT", int'(mem_taken), 0);
                if (f == 9 && c == 8)  chk("spot_1001_HI", int'(mem_taken), 0);
                if (f == 2 && c == 8)  chk("spot_0010_HI", int'(mem_taken), 1);
                if (f == 2 && c == 9)  chk("spot_0010_LS", int'(mem_taken), 0);
            end
        end

        // Flush blocks the flag write and the counter update
        setf(4'b0110);
        sv_ct  = m_ct;
        sv_cnt = m_cnt;
        drive(0, 1, 1, 4'b1111, 1, 4'hE, 0, 1);
        chk("flush_flags", int'(flags), 4'b0110);
        chk("flush_valid", int'(mem_bcond_valid), 0);
        chk("flush_cnt_t", int'(cnt_taken), sv_ct);
        chk("flush_cnt_nt", int'(cnt_not_taken), sv_cnt);

        // Stall holds MEM and flags; write applies on first unstalled edge
        drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        br(4'hE);
        chk("st_pre_valid", int'(mem_bcond_valid), 1);
        chk("st_pre_cnt_t", int'(cnt_taken), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 4'b1010, 1, 4'h0, 1, 0);
            chk("st_hold_valid", int'(mem_bcond_valid), 1);
            chk("st_hold_taken", int'(mem_taken), 1);
            chk("st_hold_flags", int'(flags), 0);
            chk("st_hold_cnt_t", int'(cnt_taken), 1);
            chk("st_hold_cnt_nt", int'(cnt_not_taken), 0);
        end
        drive(0, 1, 1, 4'b1010, 1, 4'h0, 0, 0);
        chk("st_rel_flags", int'(flags), 4'b1010);
        chk("st_rel_valid", int'(mem_bcond_valid), 1);
        chk("st_rel_taken", int'(mem_taken), 0);
        chk("st_rel_cnt_t", int'(cnt_taken), 1);
        chk("st_rel_cnt_nt", int'(cnt_not_taken), 1);
        idle();

        // Saturation of the 4-bit counters
        drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 20; i++) br(4'hE);
        chk("sat_cnt_t", int'(cnt_taken), 15);
        br(4'hF);
        chk("sat_nv_taken", int'(mem_taken), 1);
        chk("sat_nv_cnt_t", int'(cnt_taken), 15);
        chk("sat_nv_cnt_nt", int'(cnt_not_taken), 0);
        idle();
        idle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_flags_cond_unit
`default_nettype wire
